// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI byte framer.
// State encoding, SPI mode and counter sizing helper.
package spi_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  // Width of a counter that indexes bits within one frame unit.
  function automatic int cnt_width(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous pin.
// Produces the synced level plus one-cycle rise/fall strobes.
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   dly;

  // Shift the pin through the sync chain and keep one delayed copy.
  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
      dly   <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], din};
      dly   <= chain[SYNC_STAGES-1];
    end
  end

  assign level = chain[SYNC_STAGES-1];
  assign rise  = level & ~dly;
  assign fall  = ~level & dly;

endmodule

// File: rtl/spi_byte_framer.sv
// SPI mode 0 slave front end: pin sync, edge strobes,
// MSB-first byte assembly, byte strobe and miso serialiser.
module spi_byte_framer
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int BYTE_CNT_WIDTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sclk,
  input  logic                      cs_n,
  input  logic                      mosi,
  output logic                      miso,
  output logic                      sclkPosEdge,
  output logic                      sclkNegEdge,
  output logic                      sclk8PosEdge,
  output logic [DATA_WIDTH-1:0]     rxByte,
  input  logic [DATA_WIDTH-1:0]     txByte,
  output logic                      frameActive,
  output logic                      frameAbort,
  output logic [BYTE_CNT_WIDTH-1:0] byteCount
);

  localparam int BW = cnt_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST = BW'(DATA_WIDTH - 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_lvl;
  logic unused;

  state_t state, state_nx;
  logic armed;
  logic go, leave;
  logic sample_edge, launch_edge;
  logic pos_q, neg_q, last_bit;

  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] tx_shift;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_sclk (
    .clk   (clk),
    .reset (reset),
    .din   (sclk),
    .level (sclk_lvl),
    .rise  (sclk_rise),
    .fall  (sclk_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_cs (
    .clk   (clk),
    .reset (reset),
    .din   (cs_n),
    .level (cs_lvl),
    .rise  (cs_rise),
    .fall  (cs_fall)
  );

  // Data pin only needs its synced level.
  always_ff @(posedge clk) begin
    if (reset) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
  end

  assign mosi_lvl = mosi_sync[SYNC_STAGES-1];
  assign unused   = ^{sclk_lvl, cs_rise};

  // Mode 0 samples on the rising edge and launches on the falling edge.
  assign sample_edge = (CPOL ^ CPHA) ? sclk_fall : sclk_rise;
  assign launch_edge = (CPOL ^ CPHA) ? sclk_rise : sclk_fall;

  // A chip-select release in the same cycle suppresses the SCLK strobe.
  assign pos_q    = (state == ACTIVE) & ~cs_lvl & sample_edge;
  assign neg_q    = (state == ACTIVE) & ~cs_lvl & launch_edge;
  assign last_bit = (bit_cnt == LAST);

  // Arm only once chip select has been seen idle since reset.
  always_ff @(posedge clk) begin
    if (reset)       armed <= 1'b0;
    else if (cs_lvl) armed <= 1'b1;
  end

  // Frame state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Frame entry and exit decisions.
  always_comb begin
    state_nx = state;
    go       = 1'b0;
    leave    = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && cs_fall) begin
          go       = 1'b1;
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        if (cs_lvl) begin
          leave    = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign frameActive = (state == ACTIVE);

  // Registered strobes, all aligned to the qualification cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclkPosEdge  <= 1'b0;
      sclkNegEdge  <= 1'b0;
      sclk8PosEdge <= 1'b0;
      frameAbort   <= 1'b0;
    end else begin
      sclkPosEdge  <= pos_q;
      sclkNegEdge  <= neg_q;
      sclk8PosEdge <= pos_q & last_bit;
      frameAbort   <= leave & (bit_cnt != '0);
    end
  end

  // Shift registers, bit/byte counters and the miso driver.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxByte    <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      bit_cnt   <= '0;
      byteCount <= '0;
      miso      <= 1'b0;
    end else begin
      if (sclk8PosEdge) rxByte <= rx_shift;
      if (go) begin
        tx_shift <= txByte;
        miso     <= txByte[DATA_WIDTH-1];
        bit_cnt  <= '0;
      end else if (leave) begin
        rx_shift  <= '0;
        tx_shift  <= '0;
        bit_cnt   <= '0;
        byteCount <= '0;
        miso      <= 1'b0;
      end else begin
        if (pos_q) begin
          rx_shift <= {rx_shift[DATA_WIDTH-2:0], mosi_lvl};
          bit_cnt  <= last_bit ? '0 : bit_cnt + 1'b1;
          if (last_bit && (byteCount != '1))
            byteCount <= byteCount + 1'b1;
        end
        if (neg_q) begin
          if (bit_cnt == '0) begin
            tx_shift <= txByte;
            miso     <= txByte[DATA_WIDTH-1];
          end else begin
            tx_shift <= {tx_shift[DATA_WIDTH-2:0], 1'b0};
            miso     <= tx_shift[DATA_WIDTH-2];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_byte_framer.sv
// Directed bench for spi_byte_framer.
// Table of frames plus hand-written corner sequences.
module tb_spi_byte_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sclk, cs_n, mosi;
  logic        miso;
  logic        sclkPosEdge, sclkNegEdge, sclk8PosEdge;
  logic [7:0]  rxByte;
  logic [7:0]  txByte;
  logic        frameActive, frameAbort;
  logic [15:0] byteCount;

  spi_byte_framer #(
    .SYNC_STAGES(2),
    .DATA_WIDTH(8),
    .BYTE_CNT_WIDTH(16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sclk         (sclk),
    .cs_n         (cs_n),
    .mosi         (mosi),
    .miso         (miso),
    .sclkPosEdge  (sclkPosEdge),
    .sclkNegEdge  (sclkNegEdge),
    .sclk8PosEdge (sclk8PosEdge),
    .rxByte       (rxByte),
    .txByte       (txByte),
    .frameActive  (frameActive),
    .frameAbort   (frameAbort),
    .byteCount    (byteCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int pos_cnt = 0;
  int neg_cnt = 0;
  int s8_cnt  = 0;
  int ab_cnt  = 0;
  logic s8_d = 1'b0;
  logic [7:0] rx_q[$];

  // Count strobes and capture rxByte the cycle after each byte strobe.
  always @(negedge clk) begin
    if (sclkPosEdge)  pos_cnt <= pos_cnt + 1;
    if (sclkNegEdge)  neg_cnt <= neg_cnt + 1;
    if (sclk8PosEdge) s8_cnt  <= s8_cnt + 1;
    if (frameAbort)   ab_cnt  <= ab_cnt + 1;
    s8_d <= sclk8PosEdge;
    if (s8_d) rx_q.push_back(rxByte);
  end

  typedef struct {
    logic [15:0] mb;
    logic [7:0]  t0;
    logic [7:0]  t1;
    int          nb;
    int          e_s8;
    int          e_ab;
    logic [7:0]  e_rx;
    int          e_bc;
    logic [15:0] e_miso;
  } vec_t;

  vec_t vt[4];
  logic [15:0] miso_bits;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One SCLK period at clk/8; miso sampled just before the rising edge.
  task automatic put_bit(input logic b);
    mosi = b;
    wclk(4);
    miso_bits = {miso_bits[14:0], miso};
    sclk = 1'b1;
    wclk(4);
    sclk = 1'b0;
  endtask

  task automatic put_byte(input logic [7:0] b);
    for (int j = 0; j < 8; j++) put_bit(b[7-j]);
  endtask

  task automatic run_frame(input vec_t v);
    int p0, n0, s0, a0;
    logic [15:0] mask;
    p0 = pos_cnt; n0 = neg_cnt; s0 = s8_cnt; a0 = ab_cnt;
    txByte = v.t0;
    cs_n = 1'b0;
    wclk(8);
    miso_bits = '0;
    for (int i = 0; i < v.nb; i++) begin
      if (i == 4) txByte = v.t1;
      put_bit(v.mb[15-i]);
    end
    wclk(6);
    mask = 16'((32'd1 << v.nb) - 1);
    chk("pos_count", pos_cnt - p0, v.nb);
    chk("neg_count", neg_cnt - n0, v.nb);
    chk("byte_strobes", s8_cnt - s0, v.e_s8);
    chk("rxByte", int'(rxByte), int'(v.e_rx));
    chk("byteCount", int'(byteCount), v.e_bc);
    chk("miso_bits", int'(miso_bits & mask), int'(v.e_miso));
    chk("active_in_frame", int'(frameActive), 1);
    if (v.e_s8 > 0)
      chk("rx_after_strobe", int'(rx_q[$]), int'(v.e_rx));
    cs_n = 1'b1;
    wclk(8);
    chk("abort_count", ab_cnt - a0, v.e_ab);
    chk("byteCount_idle", int'(byteCount), 0);
    chk("active_idle", int'(frameActive), 0);
    chk("rx_hold", int'(rxByte), int'(v.e_rx));
  endtask

  initial begin
    int p0, n0, s0, a0, base;

    vt[0] = '{16'hA500, 8'h3C, 8'hF0, 8,  1, 0, 8'hA5, 1, 16'h003C};
    vt[1] = '{16'hC381, 8'h3C, 8'hF0, 16, 2, 0, 8'h81, 2, 16'h3CF0};
    vt[2] = '{16'hFF00, 8'h3C, 8'hF0, 5,  0, 1, 8'h81, 0, 16'h0007};
    vt[3] = '{16'h0000, 8'hFF, 8'h00, 8,  1, 0, 8'h00, 1, 16'h00FF};

    reset = 1'b1;
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0; txByte = 8'h00;
    miso_bits = '0;
    wclk(4);
    chk("rst_miso", int'(miso), 0);
    chk("rst_pos", int'(sclkPosEdge), 0);
    chk("rst_s8", int'(sclk8PosEdge), 0);
    chk("rst_rx", int'(rxByte), 0);
    chk("rst_active", int'(frameActive), 0);
    chk("rst_bc", int'(byteCount), 0);
    reset = 1'b0;
    wclk(8);

    for (int k = 0; k < 4; k++) run_frame(vt[k]);

    cs_n = 1'b0;
    wclk(8);
    for (int i = 0; i < 3; i++) put_bit(1'b1);
    reset = 1'b1;
    wclk(2);
    reset = 1'b0;
    wclk(2);
    p0 = pos_cnt; n0 = neg_cnt; s0 = s8_cnt; a0 = ab_cnt;
    for (int i = 0; i < 12; i++) put_bit(i[0]);
    wclk(6);
    chk("ignored_pos", pos_cnt - p0, 0);
    chk("ignored_neg", neg_cnt - n0, 0);
    chk("ignored_s8", s8_cnt - s0, 0);
    chk("ignored_abort", ab_cnt - a0, 0);
    chk("ignored_active", int'(frameActive), 0);
    cs_n = 1'b1;
    wclk(8);
    txByte = 8'h00;
    cs_n = 1'b0;
    wclk(8);
    put_byte(8'h5A);
    wclk(6);
    chk("rearm_rx", int'(rxByte), 8'h5A);
    chk("rearm_bc", int'(byteCount), 1);
    cs_n = 1'b1;
    wclk(8);

    cs_n = 1'b0;
    wclk(8);
    for (int i = 0; i < 3; i++) put_bit(1'b0);
    p0 = pos_cnt; a0 = ab_cnt;
    mosi = 1'b1;
    wclk(4);
    sclk = 1'b1;
    cs_n = 1'b1;
    wclk(8);
    chk("tie_pos", pos_cnt - p0, 0);
    chk("tie_active", int'(frameActive), 0);
    chk("tie_abort", ab_cnt - a0, 1);
    sclk = 1'b0;
    wclk(8);

    txByte = 8'h00;
    cs_n = 1'b0;
    wclk(8);
    base = rx_q.size();
    s0 = s8_cnt;
    for (int i = 0; i < 300; i++) put_byte(8'(i));
    wclk(6);
    chk("long_s8", s8_cnt - s0, 300);
    chk("long_bc", int'(byteCount), 300);
    chk("long_rx_n", rx_q.size() - base, 300);
    for (int i = 0; i < 300; i++) begin
      if (base + i < rx_q.size())
        chk("long_rx", int'(rx_q[base+i]), i % 256);
    end
    cs_n = 1'b1;
    wclk(8);
    chk("long_bc_idle", int'(byteCount), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_byte_framer.md
Name: spi_byte_framer

Overview:
Upstream front end for the program counter and sample memory. It synchronises the external SPI pins (sclk, cs_n, mosi) into the system clock domain and generates single-cycle strobes on SCLK rising and falling edges. It also counts bits, assembles MSB-first bytes, and issues the per-byte strobe sclk8PosEdge that advances the program counter. In parallel it serialises a transmit byte onto miso using SPI mode 0 (CPOL=0, CPHA=0).

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on each SPI input pin (minimum 2)
DATA_WIDTH, 8, bits per frame unit; sclk8PosEdge fires every DATA_WIDTH rising edges
BYTE_CNT_WIDTH, 16, width of the byte counter within a chip-select frame

Ports:
clk  input  1  system clock; single clock domain; must be at least 4x the SCLK frequency
reset  input  1  synchronous, active-high reset
sclk  input  1  raw SPI clock pin (asynchronous)
cs_n  input  1  raw SPI chip select pin, active low (asynchronous)
mosi  input  1  raw SPI data-in pin (asynchronous)
miso  output  1  SPI data-out pin
sclkPosEdge  output  1  one-cycle pulse per qualified SCLK rising edge
sclkNegEdge  output  1  one-cycle pulse per qualified SCLK falling edge
sclk8PosEdge  output  1  one-cycle pulse on the rising edge that completes a byte
rxByte  output  DATA_WIDTH  last completed received byte, held until the next completion
txByte  input  DATA_WIDTH  byte to transmit; sampled at the load points defined under Behaviour
frameActive  output  1  high while a qualified chip-select frame is in progress
frameAbort  output  1  one-cycle pulse when cs_n deasserts with a partial byte outstanding
byteCount  output  BYTE_CNT_WIDTH  number of completed bytes in the current frame

Behaviour:
- Synchronisers:
  - sclk, cs_n and mosi each pass through SYNC_STAGES flops.
  - Edge detection compares the last sync stage with one extra delay flop.
  - Pin-to-strobe latency is SYNC_STAGES+1 clk cycles.
- Reset values: miso=0, all strobes 0, rxByte=0, frameActive=0, byteCount=0, bitCnt=0, shift registers 0, armed=0.
- Arming:
  - After reset the block is disarmed.
  - It arms only after observing synchronised cs_n=1 for at least one cycle.
  - A reset that lands mid-frame therefore ignores the remainder of that frame.
- States:
  - IDLE → ACTIVE on synced cs_n falling while armed. On this transition, txByte is loaded into the TX shift register, miso is driven with its MSB, and bitCnt is set to 0.
  - ACTIVE → IDLE on synced cs_n=1.
- Qualification: sclkPosEdge and sclkNegEdge pulse only in ACTIVE. When a cs_n deassert and an SCLK edge arrive in the same cycle, cs_n wins and no strobe is issued.
- RX path:
  - On sclkPosEdge, synced mosi shifts into the RX shift register at the LSB (MSB-first on the wire), and bitCnt increments.
  - When bitCnt == DATA_WIDTH-1 at a sclkPosEdge:
    - sclk8PosEdge pulses in the same cycle as that sclkPosEdge.
    - rxByte takes the completed value on the next cycle boundary, so it is valid during the cycle after the pulse.
    - bitCnt returns to 0.
    - byteCount increments, saturating at all-ones.
- TX path:
  - On sclkNegEdge, the TX shift register shifts left and miso takes the next bit.
  - On the sclkNegEdge that follows byte completion (bitCnt==0 after a completion), txByte is reloaded and its MSB is driven instead of shifting.
- Leaving ACTIVE:
  - If bitCnt != 0, frameAbort pulses for one cycle and the partial byte is discarded; rxByte is unchanged.
  - bitCnt and byteCount clear to 0, and miso returns to 0.
- frameActive equals (state == ACTIVE).
- Reset has priority over every other event in the same cycle.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum (IDLE, ACTIVE);
  - the SPI mode constants CPOL=0 and CPHA=0;
  - a function computing the bitCnt width as clog2(DATA_WIDTH).
- One sub-module, sync_edge_detect, parameterised by SYNC_STAGES. Outputs are level, rise and fall. It is instantiated once each for sclk and cs_n; mosi uses the level output only.

Test Plan:
- Reset, then cs_n low, then one byte 0xA5 with SCLK at clk/8 → one sclk8PosEdge; rxByte=0xA5 the cycle after; byteCount=1; exactly 8 sclkPosEdge pulses.
- txByte=0x3C at cs_n fall, then 0xF0 applied before the 8th rising edge, over two bytes → miso samples 0,0,1,1,1,1,0,0 then 1,1,1,1,0,0,0,0 on rising edges.
- Five rising edges, then cs_n high → frameAbort pulses once; rxByte keeps its previous value; byteCount=0; no sclk8PosEdge.
- Reset asserted mid-byte while cs_n stays low for 12 more edges → no strobes at all. Then cs_n high, then a new frame with 0x5A → rxByte=0x5A.
- SCLK rising edge and cs_n deassert aligned to the same synced cycle → no sclkPosEdge; frameActive drops.
- 300 consecutive bytes 0x00..0xFF with wrap, no cs_n gap → 300 sclk8PosEdge pulses; byteCount=300; each rxByte matches its sent byte.
